// File: rtl/sys_ctrl_if.sv
// Bus bundle between sys_ctrl and its RX, register-file, ALU and TX FIFO neighbours.
// master is the controller's view; slave is the surrounding datapath's view.
interface sys_ctrl_if #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned ASIZE = 4
);
    logic [DSIZE-1:0]   RX_P_DATA;
    logic               RX_D_VLD;
    logic [DSIZE-1:0]   RdData;
    logic               RdData_Valid;
    logic [2*DSIZE-1:0] ALU_OUT;
    logic               OUT_Valid;
    logic               FIFO_FULL;
    logic               WrEn;
    logic               RdEn;
    logic [ASIZE-1:0]   Address;
    logic [DSIZE-1:0]   WrData;
    logic               ALU_EN;
    logic [3:0]         ALU_FUN;
    logic               CLK_GATE_EN;
    logic [DSIZE-1:0]   TX_P_DATA;
    logic               TX_D_VLD;

    modport master (
        input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, FIFO_FULL,
        output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, FIFO_FULL,
        input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD
    );
endinterface

// File: rtl/sys_ctrl.sv
// Command controller: decodes RX bytes into register-file / ALU operations and returns results
// to the TX FIFO. Define SYS_CTRL_ALU_EN to enable the 0xCC/0xDD ALU commands.
module sys_ctrl #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned ASIZE = 4
) (
    input  logic          CLK,
    input  logic          RST,
    sys_ctrl_if.master    bus
);

    localparam logic [DSIZE-1:0] CmdWr     = DSIZE'(8'hAA);
    localparam logic [DSIZE-1:0] CmdRd     = DSIZE'(8'hBB);
`ifdef SYS_CTRL_ALU_EN
    localparam logic [DSIZE-1:0] CmdAlu    = DSIZE'(8'hCC);
    localparam logic [DSIZE-1:0] CmdAluNop = DSIZE'(8'hDD);
`endif

    typedef enum logic [3:0] {
        StIdle,
        StWrAddr,
        StWrData,
        StRdAddr,
        StRdWait,
        StTxRd
`ifdef SYS_CTRL_ALU_EN
        ,
        StOpA,
        StOpB,
        StAluFun,
        StAluWait,
        StTxLo,
        StTxHi
`endif
    } state_e;

    state_e           state_q;
    logic [DSIZE-1:0] rd_data_q;
`ifdef SYS_CTRL_ALU_EN
    logic [2*DSIZE-1:0] res_q;
`else
    // ALU inputs are unused when the ALU commands are compiled out
    logic unused_alu;
    assign unused_alu      = ^{bus.ALU_OUT, bus.OUT_Valid};
    assign bus.ALU_EN      = 1'b0;
    assign bus.ALU_FUN     = 4'h0;
    assign bus.CLK_GATE_EN = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q         <= StIdle;
            rd_data_q       <= '0;
            bus.WrEn        <= 1'b0;
            bus.RdEn        <= 1'b0;
            bus.Address     <= '0;
            bus.WrData      <= '0;
            bus.TX_P_DATA   <= '0;
            bus.TX_D_VLD    <= 1'b0;
`ifdef SYS_CTRL_ALU_EN
            res_q           <= '0;
            bus.ALU_EN      <= 1'b0;
            bus.ALU_FUN     <= 4'h0;
            bus.CLK_GATE_EN <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle unless re-armed below
            bus.WrEn     <= 1'b0;
            bus.RdEn     <= 1'b0;
            bus.TX_D_VLD <= 1'b0;
`ifdef SYS_CTRL_ALU_EN
            bus.ALU_EN   <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    if (bus.RX_D_VLD) begin
                        if (bus.RX_P_DATA == CmdWr) begin
                            state_q <= StWrAddr;
                        end else if (bus.RX_P_DATA == CmdRd) begin
                            state_q <= StRdAddr;
`ifdef SYS_CTRL_ALU_EN
                        end else if (bus.RX_P_DATA == CmdAlu) begin
                            state_q         <= StOpA;
                            bus.CLK_GATE_EN <= 1'b1;
                        end else if (bus.RX_P_DATA == CmdAluNop) begin
                            state_q         <= StAluFun;
                            bus.CLK_GATE_EN <= 1'b1;
`endif
                        end
                    end
                end
                StWrAddr: begin
                    if (bus.RX_D_VLD) begin
                        bus.Address <= bus.RX_P_DATA[ASIZE-1:0];
                        state_q     <= StWrData;
                    end
                end
                StWrData: begin
                    if (bus.RX_D_VLD) begin
                        bus.WrEn   <= 1'b1;
                        bus.WrData <= bus.RX_P_DATA;
                        state_q    <= StIdle;
                    end
                end
                StRdAddr: begin
                    if (bus.RX_D_VLD) begin
                        bus.Address <= bus.RX_P_DATA[ASIZE-1:0];
                        bus.RdEn    <= 1'b1;
                        state_q     <= StRdWait;
                    end
                end
                StRdWait: begin
                    if (bus.RdData_Valid) begin
                        rd_data_q <= bus.RdData;
                        state_q   <= StTxRd;
                    end
                end
                StTxRd: begin
                    if (!bus.FIFO_FULL) begin
                        bus.TX_D_VLD  <= 1'b1;
                        bus.TX_P_DATA <= rd_data_q;
                        state_q       <= StIdle;
                    end
                end
`ifdef SYS_CTRL_ALU_EN
                StOpA: begin
                    if (bus.RX_D_VLD) begin
                        bus.WrEn    <= 1'b1;
                        bus.Address <= ASIZE'(0);
                        bus.WrData  <= bus.RX_P_DATA;
                        state_q     <= StOpB;
                    end
                end
                StOpB: begin
                    if (bus.RX_D_VLD) begin
                        bus.WrEn    <= 1'b1;
                        bus.Address <= ASIZE'(1);
                        bus.WrData  <= bus.RX_P_DATA;
                        state_q     <= StAluFun;
                    end
                end
                StAluFun: begin
                    if (bus.RX_D_VLD) begin
                        bus.ALU_EN  <= 1'b1;
                        bus.ALU_FUN <= bus.RX_P_DATA[3:0];
                        state_q     <= StAluWait;
                    end
                end
                StAluWait: begin
                    if (bus.OUT_Valid) begin
                        res_q           <= bus.ALU_OUT;
                        bus.CLK_GATE_EN <= 1'b0;
                        state_q         <= StTxLo;
                    end
                end
                StTxLo: begin
                    if (!bus.FIFO_FULL) begin
                        bus.TX_D_VLD  <= 1'b1;
                        bus.TX_P_DATA <= res_q[DSIZE-1:0];
                        state_q       <= StTxHi;
                    end
                end
                StTxHi: begin
                    if (!bus.FIFO_FULL) begin
                        bus.TX_D_VLD  <= 1'b1;
                        bus.TX_P_DATA <= res_q[2*DSIZE-1:DSIZE];
                        state_q       <= StIdle;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed bench for sys_ctrl: register write/read, ALU commands (when SYS_CTRL_ALU_EN is
// defined), TX back-pressure, unknown commands and mid-command reset.
module tb_sys_ctrl;
    localparam int unsigned DSIZE = 8;
    localparam int unsigned ASIZE = 4;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    sys_ctrl_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus ();

    sys_ctrl #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int rd_cnt  = 0;
    int alu_cnt = 0;
    int both_cnt = 0;
    logic [7:0] tx_q[$];

    // Strobes are registered and last a whole cycle, so one sample per negedge counts pulses
    always @(negedge CLK) begin
        if (bus.WrEn) wr_cnt++;
        if (bus.RdEn) rd_cnt++;
        if (bus.ALU_EN) alu_cnt++;
        if (bus.WrEn && bus.RdEn) both_cnt++;
        if (bus.TX_D_VLD) tx_q.push_back(bus.TX_P_DATA);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        tick(1);
        bus.RX_D_VLD  = 1'b0;
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.WrEn, bus.RdEn, bus.Address, bus.WrData, bus.ALU_EN, bus.ALU_FUN,
                    bus.CLK_GATE_EN, bus.TX_D_VLD, bus.TX_P_DATA});
    endfunction

    int w0, r0, a0;

    initial begin
        bus.RX_P_DATA    = '0;
        bus.RX_D_VLD     = 1'b0;
        bus.RdData       = '0;
        bus.RdData_Valid = 1'b0;
        bus.ALU_OUT      = '0;
        bus.OUT_Valid    = 1'b0;
        bus.FIFO_FULL    = 1'b0;
        #12;
        check("reset_outs", outs(), 32'h0);
        @(negedge CLK);
        RST = 1'b1;
        tick(1);

        // Register write: AA 05 3C
        w0 = wr_cnt;
        send(8'hAA);
        send(8'h05);
        send(8'h3C);
        check("wr_strobe", {bus.WrEn, bus.RdEn, bus.Address, bus.WrData}, {1'b1, 1'b0, 4'h5, 8'h3C});
        tick(1);
        check("wr_deassert", bus.WrEn, 1'b0);
        tick(1);
        check("wr_pulses", wr_cnt - w0, 1);

        // Register read: BB 02, stray byte ignored in RD_WAIT, then RdData 0x81
        w0 = wr_cnt;
        r0 = rd_cnt;
        tx_q.delete();
        send(8'hBB);
        send(8'h02);
        check("rd_strobe", {bus.RdEn, bus.WrEn, bus.Address}, {1'b1, 1'b0, 4'h2});
        tick(1);
        check("rd_deassert", bus.RdEn, 1'b0);
        send(8'hAA);
        bus.RdData       = 8'h81;
        bus.RdData_Valid = 1'b1;
        tick(1);
        bus.RdData_Valid = 1'b0;
        check("rd_tx_not_yet", bus.TX_D_VLD, 1'b0);
        tick(1);
        check("rd_tx_byte", {bus.TX_D_VLD, bus.TX_P_DATA}, {1'b1, 8'h81});
        tick(1);
        check("rd_tx_deassert", bus.TX_D_VLD, 1'b0);
        check("rd_pulses", rd_cnt - r0, 1);
        check("rd_tx_count", tx_q.size(), 1);
        send(8'h07);
        send(8'h09);
        tick(2);
        check("wait_byte_ignored", wr_cnt - w0, 0);

        // Read with FIFO back-pressure
        tx_q.delete();
        send(8'hBB);
        send(8'h07);
        tick(1);
        bus.RdData       = 8'h5A;
        bus.RdData_Valid = 1'b1;
        bus.FIFO_FULL    = 1'b1;
        tick(1);
        bus.RdData_Valid = 1'b0;
        tick(3);
        check("rd_full_hold", tx_q.size(), 0);
        bus.FIFO_FULL = 1'b0;
        tick(1);
        check("rd_full_release", {bus.TX_D_VLD, bus.TX_P_DATA}, {1'b1, 8'h5A});

        // Unknown command bytes in IDLE
        tick(1);
        w0 = wr_cnt;
        r0 = rd_cnt;
        tx_q.delete();
        send(8'h55);
        send(8'h05);
        send(8'h3C);
        tick(2);
        check("unknown_pulses", (wr_cnt - w0) + (rd_cnt - r0) + tx_q.size(), 0);
        check("unknown_outs_idle", {bus.WrEn, bus.RdEn, bus.TX_D_VLD, bus.ALU_EN}, 4'h0);

`ifdef SYS_CTRL_ALU_EN
        // ALU with operands: CC 10 20 00, result 0x0030
        w0 = wr_cnt;
        a0 = alu_cnt;
        tx_q.delete();
        send(8'hCC);
        check("alu_cg_opa", bus.CLK_GATE_EN, 1'b1);
        send(8'h10);
        check("alu_op_a", {bus.WrEn, bus.Address, bus.WrData}, {1'b1, 4'h0, 8'h10});
        send(8'h20);
        check("alu_op_b", {bus.WrEn, bus.Address, bus.WrData}, {1'b1, 4'h1, 8'h20});
        send(8'h00);
        check("alu_en", {bus.ALU_EN, bus.ALU_FUN, bus.CLK_GATE_EN}, {1'b1, 4'h0, 1'b1});
        tick(1);
        check("alu_wait", {bus.ALU_EN, bus.CLK_GATE_EN}, 2'b01);
        bus.ALU_OUT   = 16'h0030;
        bus.OUT_Valid = 1'b1;
        tick(1);
        bus.OUT_Valid = 1'b0;
        check("alu_cg_off", bus.CLK_GATE_EN, 1'b0);
        tick(3);
        check("alu_tx_count", tx_q.size(), 2);
        if (tx_q.size() == 2) begin
            check("alu_tx_lo", tx_q[0], 8'h30);
            check("alu_tx_hi", tx_q[1], 8'h00);
        end
        check("alu_wr_pulses", wr_cnt - w0, 2);
        check("alu_en_pulses", alu_cnt - a0, 1);

        // ALU without operands, FIFO full for 5 cycles in TX_LO
        tx_q.delete();
        send(8'hDD);
        check("nop_cg", bus.CLK_GATE_EN, 1'b1);
        send(8'h05);
        check("nop_fun", {bus.ALU_EN, bus.ALU_FUN}, {1'b1, 4'h5});
        tick(1);
        bus.ALU_OUT   = 16'h0030;
        bus.OUT_Valid = 1'b1;
        bus.FIFO_FULL = 1'b1;
        tick(1);
        bus.OUT_Valid = 1'b0;
        tick(5);
        check("full_hold", tx_q.size(), 0);
        bus.FIFO_FULL = 1'b0;
        tick(4);
        check("full_tx_count", tx_q.size(), 2);
        if (tx_q.size() == 2) begin
            check("full_tx_lo", tx_q[0], 8'h30);
            check("full_tx_hi", tx_q[1], 8'h00);
        end

        // Reset pulse while in ALU_WAIT
        tx_q.delete();
        a0 = alu_cnt;
        send(8'hDD);
        send(8'h03);
        tick(1);
        #2 RST = 1'b0;
        #1 check("rst_mid_outs", outs(), 32'h0);
        @(negedge CLK);
        RST           = 1'b1;
        bus.OUT_Valid = 1'b1;
        tick(1);
        bus.OUT_Valid = 1'b0;
        tick(4);
        check("rst_no_tx", tx_q.size(), 0);
        check("rst_idle_outs", outs(), 32'h0);
`else
        // ALU commands are dropped as unknown
        w0 = wr_cnt;
        a0 = alu_cnt;
        send(8'hCC);
        send(8'h10);
        send(8'h20);
        send(8'h00);
        send(8'hDD);
        send(8'h05);
        tick(2);
        check("alu_off_wr", wr_cnt - w0, 0);
        check("alu_off_en", {bus.ALU_EN, bus.ALU_FUN, bus.CLK_GATE_EN} | 6'(alu_cnt - a0), 6'h0);

        // Reset pulse while in RD_WAIT
        tx_q.delete();
        r0 = rd_cnt;
        send(8'hBB);
        send(8'h03);
        tick(1);
        #2 RST = 1'b0;
        #1 check("rst_mid_outs", outs(), 32'h0);
        @(negedge CLK);
        RST              = 1'b1;
        bus.RdData       = 8'hE7;
        bus.RdData_Valid = 1'b1;
        tick(1);
        bus.RdData_Valid = 1'b0;
        tick(4);
        check("rst_no_tx", tx_q.size(), 0);
        check("rst_idle_outs", outs(), 32'h0);
`endif

        check("wr_rd_exclusive", both_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
